// File: rtl/conv_pkg.sv
// Shared sizing helpers and result-shaping functions for the convolution MAC pipeline.
package conv_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int kk_of(input int k);
        return k * k;
    endfunction

    function automatic int tree_d(input int k);
        return clog2(k * k);
    endfunction

    function automatic int acc_w(input int dw, input int k);
        return 2 * dw + clog2(k * k);
    endfunction

    function automatic int lvl_w(input int dw, input int lvl);
        return 2 * dw + lvl;
    endfunction

    // Operand count entering tree level lvl (each level halves, rounding up).
    function automatic int lvl_n(input int kk, input int lvl);
        int n;
        n = kk;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] s, input int out_w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] s, input logic en);
        if (en && (s < 0)) return '0;
        return s;
    endfunction

endpackage

// File: rtl/conv_mac_pipe_adder_tree_lvl.sv
// One registered level of the adder tree: pairs sign-extended operands, odd one passes through.
module adder_tree_lvl #(
    parameter  int N_IN  = 9,
    parameter  int IN_W  = 16,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int SUM_W = IN_W + 1
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [N_IN*IN_W-1:0]   in_data,
    output logic [N_OUT*SUM_W-1:0] sum_o
);

    logic [N_OUT*SUM_W-1:0] sum_d, sum_q;
    logic signed [SUM_W-1:0] a, b;
    int idx;

    always_comb begin
        sum_d = '0;
        a     = '0;
        b     = '0;
        idx   = 0;
        for (int j = 0; j < N_OUT; j++) begin
            idx = (2 * j + 1 < N_IN) ? 2 * j + 1 : 2 * j;
            a   = SUM_W'($signed(in_data[2*j*IN_W +: IN_W]));
            b   = SUM_W'($signed(in_data[idx*IN_W +: IN_W]));
            if (2 * j + 1 >= N_IN) b = '0;
            sum_d[j*SUM_W +: SUM_W] = a + b;
        end
    end

    always_ff @(posedge clk) begin
        if (en) sum_q <= sum_d;
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed KxK window dot product + bias, optional ReLU, saturate or wrap.
// Single global stall: every stage advances when the output register is free or draining.
module conv_mac_pipe
    import conv_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int K     = 3,
    parameter  int OUT_W = 16,
    parameter  int SAT   = 1,
    localparam int KK    = K * K,
    localparam int D     = clog2(KK),
    localparam int ACC_W = 2 * DW + D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW*KK-1:0]   in_win,
    input  logic [DW*KK-1:0]   in_wgt,
    input  logic [ACC_W-1:0]   in_bias,
    input  logic               in_relu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data
);

    localparam int PW = 2 * DW;

    logic                  adv;
    logic [KK*PW-1:0]      prod_d, prod_q;
    logic signed [PW-1:0]  pa, pb;
    logic [D:0]            vld_q, relu_q;
    logic [ACC_W-1:0]      bias_q [D+1];
    logic [ACC_W-1:0]      sum_fin;
    logic                  out_valid_q;
    logic [OUT_W-1:0]      out_data_d, out_data_q;
    logic signed [63:0]    s_full, s_relu, s_clip;
    logic                  unused_hi;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        prod_d = '0;
        pa     = '0;
        pb     = '0;
        for (int i = 0; i < KK; i++) begin
            pa = PW'($signed(in_win[(KK-1-i)*DW +: DW]));
            pb = PW'($signed(in_wgt[(KK-1-i)*DW +: DW]));
            prod_d[i*PW +: PW] = pa * pb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i <= D; i++) vld_q[i] <= vld_q[i-1];
            out_valid_q <= vld_q[D];
            out_data_q  <= out_data_d;
        end
    end

    // Payload registers carry no reset; the valid chain qualifies them.
    always_ff @(posedge clk) begin
        if (adv) begin
            prod_q    <= prod_d;
            bias_q[0] <= in_bias;
            relu_q[0] <= in_relu;
            for (int i = 1; i <= D; i++) begin
                bias_q[i] <= bias_q[i-1];
                relu_q[i] <= relu_q[i-1];
            end
        end
    end

    generate
        if (D == 0) begin : g_bypass
            assign sum_fin = prod_q;
        end else begin : g_tree
            for (genvar l = 0; l < D; l++) begin : g_lvl
                localparam int NI = lvl_n(KK, l);
                localparam int WI = lvl_w(DW, l);
                localparam int NO = (NI + 1) / 2;
                logic [NI*WI-1:0]     din;
                logic [NO*(WI+1)-1:0] sum;
                if (l == 0) begin : g_first
                    assign din = prod_q;
                end else begin : g_next
                    assign din = g_lvl[l-1].sum;
                end
                adder_tree_lvl #(.N_IN(NI), .IN_W(WI)) u_lvl (
                    .clk     (clk),
                    .en      (adv),
                    .in_data (din),
                    .sum_o   (sum)
                );
            end
            assign sum_fin = g_lvl[D-1].sum;
        end
    endgenerate

    always_comb begin
        s_full     = 64'($signed(sum_fin)) + 64'($signed(bias_q[D]));
        s_relu     = relu(s_full, relu_q[D]);
        s_clip     = (SAT != 0) ? sat_clip(s_relu, OUT_W) : s_relu;
        out_data_d = s_clip[OUT_W-1:0];
    end

    assign unused_hi = ^s_clip[63:OUT_W];

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Bench for conv_mac_pipe: saturating and wrapping instances share stimulus; a queue model
// computes each expected result from the arithmetic definition at input acceptance.
module tb_conv_mac_pipe;
    localparam int DW = 8, K = 3, KK = 9, OUT_W = 16, ACC_W = 20, WW = 72;

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_relu = 0, out_ready = 1;
    logic [WW-1:0] in_win = '0, in_wgt = '0;
    logic [ACC_W-1:0] in_bias = '0;
    logic rdy_s, rdy_w, ov_s, ov_w;
    logic [OUT_W-1:0] od_s, od_w;

    int checks = 0, errors = 0;
    int ready_mode = 0;
    int cyc = 0, n_out = 0, first_out = -1, last_out = -1;
    logic held = 0;
    logic [OUT_W-1:0] hs, hw;

    typedef struct { logic [15:0] s; logic [15:0] w; } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    conv_mac_pipe #(.DW(DW), .K(K), .OUT_W(OUT_W), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_win(in_win), .in_wgt(in_wgt), .in_bias(in_bias), .in_relu(in_relu),
        .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s));

    conv_mac_pipe #(.DW(DW), .K(K), .OUT_W(OUT_W), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w),
        .in_win(in_win), .in_wgt(in_wgt), .in_bias(in_bias), .in_relu(in_relu),
        .out_valid(ov_w), .out_ready(out_ready), .out_data(od_w));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int model_raw(input logic [WW-1:0] w, input logic [WW-1:0] g,
                                     input logic [ACC_W-1:0] b, input logic r);
        int acc;
        logic signed [7:0] pa, pb;
        acc = 0;
        for (int i = 0; i < KK; i++) begin
            pa = w[(KK-1-i)*DW +: DW];
            pb = g[(KK-1-i)*DW +: DW];
            acc += int'(pa) * int'(pb);
        end
        acc += int'($signed(b));
        if (r && acc < 0) acc = 0;
        return acc;
    endfunction

    function automatic logic [15:0] to_sat(input int v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [15:0] to_wrap(input int v);
        return v[15:0];
    endfunction

    function automatic logic [WW-1:0] pk(input int start, input int step);
        logic [WW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < KK; i++) begin
            v = start + step * i;
            r[(KK-1-i)*DW +: DW] = v[7:0];
        end
        return r;
    endfunction

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        int raw;
        if (!rst_n) begin
            exp_q.delete();
            held = 0;
        end else begin
            cyc++;
            chk("in_ready_rule", {31'd0, rdy_s}, {31'd0, (!ov_s || out_ready)});
            chk("twin_valid", {31'd0, ov_w}, {31'd0, ov_s});
            if (held) begin
                chk("hold_valid", {31'd0, ov_s}, 32'd1);
                chk("hold_sat", {16'd0, od_s}, {16'd0, hs});
                chk("hold_wrap", {16'd0, od_w}, {16'd0, hw});
            end
            held = ov_s && !out_ready;
            hs = od_s;
            hw = od_w;
            if (ov_s && out_ready) begin
                if (exp_q.size() == 0) chk("out_with_empty_queue", {31'd0, ov_s}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("data_sat", {16'd0, od_s}, {16'd0, e.s});
                    chk("data_wrap", {16'd0, od_w}, {16'd0, e.w});
                end
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_valid && rdy_s) begin
                raw = model_raw(in_win, in_wgt, in_bias, in_relu);
                e.s = to_sat(raw);
                e.w = to_wrap(raw);
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [WW-1:0] w, input logic [WW-1:0] g,
                        input logic [ACC_W-1:0] b, input logic r, output int waits);
        int budget;
        logic ok;
        budget = 0;
        waits = 0;
        in_win = w; in_wgt = g; in_bias = b; in_relu = r; in_valid = 1;
        do begin
            @(negedge clk);
            ok = rdy_s;
            @(posedge clk);
            #1;
            if (!ok) waits++;
            budget++;
        end while (!ok && budget < 300);
        if (!ok) chk("send_timeout", {31'd0, ok}, 32'd1);
        in_valid = 0;
    endtask

    task automatic send_rand(output int waits);
        logic [95:0] t;
        logic [31:0] rb;
        int bi;
        t = {$urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, 1) == 1) begin
            bi = int'($urandom_range(0, 4000)) - 2000;
            rb = bi;
        end else rb = $urandom();
        send(t[71:0], {t[35:0], t[71:36]} ^ 72'($urandom()), rb[19:0], 1'($urandom_range(0, 1)), waits);
    endtask

    task automatic run_one(input string nm, input logic [WW-1:0] w, input logic [WW-1:0] g,
                           input logic [ACC_W-1:0] b, input logic r,
                           input logic [15:0] es, input logic [15:0] ew);
        int lat, waits;
        send(w, g, b, r, waits);
        lat = 1;
        while (!ov_s && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 32'd6);
        chk({nm, "_sat"}, {16'd0, od_s}, {16'd0, es});
        chk({nm, "_wrap"}, {16'd0, od_w}, {16'd0, ew});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || ov_s) && budget < 400) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("drain_timeout", {31'd0, (exp_q.size() != 0 || ov_s)}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits, seen, budget;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {30'd0, ov_s, ov_w}, 32'd0);
        chk("rst_out_data_sat", {16'd0, od_s}, 32'd0);
        chk("rst_out_data_wrap", {16'd0, od_w}, 32'd0);
        chk("rst_in_ready", {30'd0, rdy_s, rdy_w}, 32'd3);
        rst_n = 1;
        @(posedge clk);
        #1;

        chk("model_basic", {16'd0, to_sat(model_raw(pk(1, 1), pk(9, -1), '0, 0))}, 32'h00A5);
        chk("model_wrap", {16'd0, to_wrap(model_raw(pk(-128, 0), pk(-128, 0), '0, 0))}, 32'h4000);
        chk("model_bias", {16'd0, to_sat(model_raw(pk(1, 1), pk(9, -1), 20'(-200), 0))}, 32'hFFDD);

        run_one("basic", pk(1, 1), pk(9, -1), '0, 0, 16'h00A5, 16'h00A5);
        run_one("satwrap", pk(-128, 0), pk(-128, 0), '0, 0, 16'h7FFF, 16'h4000);
        run_one("bias", pk(1, 1), pk(9, -1), 20'(-200), 0, 16'hFFDD, 16'hFFDD);
        run_one("relu", pk(1, 1), pk(9, -1), 20'(-200), 1, 16'h0000, 16'h0000);
        run_one("neg", pk(1, 0), pk(-1, 0), '0, 0, 16'hFFF7, 16'hFFF7);

        n_out = 0; first_out = -1; last_out = -1;
        for (int i = 0; i < 20; i++) begin
            send_rand(waits);
            chk("stream_in_ready", waits, 32'd0);
        end
        wait_empty();
        chk("stream_count", n_out, 32'd20);
        chk("stream_one_per_cycle", last_out - first_out, 32'd19);

        n_out = 0;
        seen = 0;
        fork
            begin
                repeat (8) @(posedge clk);
                ready_mode = 2;
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    send_rand(waits);
                    seen += waits;
                end
            end
        join
        wait_empty();
        chk("stall_count", n_out, 32'd15);
        chk("stall_observed", {31'd0, (seen >= 4)}, 32'd1);

        n_out = 0;
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rand(waits);
        end
        ready_mode = 0;
        wait_empty();
        chk("random_count", n_out, 32'd200);

        ready_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_rand(waits);
        budget = 0;
        while (!ov_s && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("pre_reset_valid", {31'd0, ov_s}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("async_reset_valid", {30'd0, ov_s, ov_w}, 32'd0);
        chk("async_reset_data", {od_s, od_w}, 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1;
        ready_mode = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov_s || ov_w) seen++;
        end
        chk("no_stale_out", seen, 32'd0);
        @(posedge clk);
        #1;
        run_one("post_reset", pk(1, 1), pk(9, -1), '0, 0, 16'h00A5, 16'h00A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
